// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM
// state encoding and the data-path width.
package lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_e;

  // The reserved size code 2'b11 behaves as a word access.
  function automatic logic [1:0] effective_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// EX/MEM request, data-memory and MEM/WB signals of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding pipeline.
interface load_store_unit_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) ();
  import lsu_pkg::*;

  logic                      ex_valid;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [1:0]                ex_size;
  logic                      ex_unsigned;
  logic [DATA_WIDTH-1:0]     ex_address;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      stall;
  logic                      dm_write_enable;
  logic [DATA_WIDTH-1:0]     dm_address;
  logic [DATA_WIDTH-1:0]     dm_write_data;
  logic [DATA_WIDTH-1:0]     dm_read_data;
  logic                      wb_valid;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic                      wb_reg_write;
  logic                      misaligned;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
           ex_address, ex_store_data, ex_rd, ex_reg_write, dm_read_data,
    output stall, dm_write_enable, dm_address, dm_write_data,
           wb_valid, wb_data, wb_rd, wb_reg_write, misaligned
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
           ex_address, ex_store_data, ex_rd, ex_reg_write, dm_read_data,
    input  stall, dm_write_enable, dm_address, dm_write_data,
           wb_valid, wb_data, wb_rd, wb_reg_write, misaligned
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a loaded byte/half from a
// memory word, and merges a store byte/half into an existing word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic [1:0]            size,
  input  logic [1:0]            offset,
  input  logic                  load_unsigned,
  output logic [DATA_WIDTH-1:0] load_result,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] merged_word
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [1:0]  size_eff;

  always_comb begin
    size_eff  = effective_size(size);
    load_byte = load_word[{offset, 3'b000} +: 8];
    load_half = offset[1] ? load_word[31:16] : load_word[15:0];
    case (size_eff)
      SIZE_BYTE: load_result = {{24{~load_unsigned & load_byte[7]}}, load_byte};
      SIZE_HALF: load_result = {{16{~load_unsigned & load_half[15]}}, load_half};
      default:   load_result = load_word;
    endcase
  end

  always_comb begin
    merged_word = old_word;
    case (size_eff)
      SIZE_BYTE: merged_word[{offset, 3'b000} +: 8]  = store_data[7:0];
      SIZE_HALF: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default:   merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_CHECK_EN to suppress and flag misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned           REG_ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] WB_RESET_DATA  = 32'h0000_0000
) (
  input  logic            system_clock,
  input  logic            reset,
  load_store_unit_if.slave lsu
);

  lsu_state_e            state;
  logic [DATA_WIDTH-1:0] merge_reg;
  logic [DATA_WIDTH-1:0] load_result;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [1:0]            size_eff;
  logic                  is_store;
  logic                  is_load;
  logic                  is_subword;
  logic                  misalign_hit;

  lsu_lane_align u_lane_align (
    .load_word     (lsu.dm_read_data),
    .size          (lsu.ex_size),
    .offset        (lsu.ex_address[1:0]),
    .load_unsigned (lsu.ex_unsigned),
    .load_result   (load_result),
    .old_word      (lsu.dm_read_data),
    .store_data    (lsu.ex_store_data),
    .merged_word   (merged_word)
  );

  always_comb begin
    size_eff   = effective_size(lsu.ex_size);
    is_store   = lsu.ex_valid & lsu.ex_mem_write;
    is_load    = lsu.ex_valid & lsu.ex_mem_read & ~lsu.ex_mem_write;
    is_subword = (size_eff != SIZE_WORD);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned_q;

  always_comb begin
    misalign_hit = (is_store | is_load) &
                   (((size_eff == SIZE_HALF) & lsu.ex_address[0]) |
                    ((size_eff == SIZE_WORD) & (lsu.ex_address[1:0] != 2'b00)));
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= (state == IDLE) & misalign_hit;
  end

  assign lsu.misaligned = misaligned_q;
`else
  assign misalign_hit   = 1'b0;
  assign lsu.misaligned = 1'b0;
`endif

  // Memory-side controls are decoded from state so an asynchronous reset
  // kills a pending RMW write in the same cycle.
  always_comb begin
    lsu.dm_address      = {lsu.ex_address[31:2], 2'b00};
    lsu.stall           = ~reset & (state == IDLE) & is_store & is_subword & ~misalign_hit;
    lsu.dm_write_enable = ~reset &
                          ((state == RMW_WRITE) |
                           ((state == IDLE) & is_store & ~is_subword & ~misalign_hit));
    lsu.dm_write_data   = (state == RMW_WRITE) ? merge_reg : lsu.ex_store_data;
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      merge_reg        <= '0;
      lsu.wb_valid     <= 1'b0;
      lsu.wb_reg_write <= 1'b0;
      lsu.wb_rd        <= '0;
      lsu.wb_data      <= WB_RESET_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (!lsu.ex_valid) begin
            lsu.wb_valid     <= 1'b0;
            lsu.wb_reg_write <= 1'b0;
          end else if (misalign_hit) begin
            lsu.wb_valid     <= 1'b1;
            lsu.wb_reg_write <= 1'b0;
            lsu.wb_rd        <= lsu.ex_rd;
          end else if (is_store) begin
            lsu.wb_rd        <= lsu.ex_rd;
            lsu.wb_reg_write <= 1'b0;
            if (is_subword) begin
              merge_reg    <= merged_word;
              state        <= RMW_WRITE;
              lsu.wb_valid <= 1'b0;
            end else begin
              lsu.wb_valid <= 1'b1;
            end
          end else if (is_load) begin
            lsu.wb_data      <= load_result;
            lsu.wb_valid     <= 1'b1;
            lsu.wb_reg_write <= lsu.ex_reg_write;
            lsu.wb_rd        <= lsu.ex_rd;
          end else begin
            lsu.wb_data      <= lsu.ex_address;
            lsu.wb_valid     <= 1'b1;
            lsu.wb_reg_write <= lsu.ex_reg_write;
            lsu.wb_rd        <= lsu.ex_rd;
          end
        end
        RMW_WRITE: begin
          state            <= IDLE;
          lsu.wb_valid     <= 1'b1;
          lsu.wb_reg_write <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage front end that sits between the EX/MEM pipeline register and the word-addressed data memory.
- Handles byte, halfword and word loads and stores.
- Because the data memory only writes whole words, sub-word stores run as a two-cycle read-modify-write and stall the pipeline for one cycle.
- Registers the MEM/WB result: the loaded value, or the ALU result passed through for non-memory operations.

Parameters:
- REG_ADDR_WIDTH, 5: width of the destination register index.
- WB_RESET_DATA, 32'h0000_0000: reset value of wb_data.

Ports:
- system_clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ex_unsigned  in  1  zero-extend loads (lbu/lhu) when set, else sign-extend.
- ex_address  in  32  ALU result / effective address.
- ex_store_data  in  32  rt value; the low byte or half is used for sub-word stores.
- ex_rd  in  REG_ADDR_WIDTH  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- stall  out  1  hold the upstream pipeline this cycle.
- dm_write_enable  out  1  to data memory.
- dm_address  out  32  to data memory; always {ex_address[31:2],2'b00}.
- dm_write_data  out  32  to data memory.
- dm_read_data  in  32  from data memory; asynchronous read.
- wb_valid  out  1  MEM/WB entry valid.
- wb_data  out  32  load result or passed-through ALU result.
- wb_rd  out  REG_ADDR_WIDTH  MEM/WB destination register.
- wb_reg_write  out  1  MEM/WB register-file write enable.
- misaligned  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (async, active-high) forces:
  - state to IDLE;
  - stall, dm_write_enable, wb_valid, wb_reg_write and misaligned to 0;
  - wb_rd to 0 and wb_data to WB_RESET_DATA.
- States are IDLE and RMW_WRITE.
- IDLE, ex_valid=0: no memory write. Next edge: wb_valid=0, wb_reg_write=0.
- IDLE, non-memory op (read=0, write=0): next edge latches ex_address→wb_data, ex_rd→wb_rd, ex_reg_write→wb_reg_write, and sets wb_valid=1. Latency is 1.
- IDLE, load:
  - Select the lane from dm_read_data: byte lane = address[1:0]; half lane = address[1].
  - Little-endian: byte 0 = bits [7:0].
  - Sign- or zero-extend per ex_unsigned.
  - Next edge latches the result to wb_data with wb_valid=1; wb_reg_write follows ex_reg_write. Latency is 1, no stall.
- IDLE, word store:
  - Same cycle: dm_write_enable=1, dm_write_data=ex_store_data.
  - Next edge: wb_valid=1, wb_reg_write=0. No stall.
- IDLE, sub-word store:
  - Same cycle: stall=1, dm_write_enable=0.
  - On the edge: merge the store lane into dm_read_data, register the merged word in merge_reg, go to RMW_WRITE, wb_valid=0.
  - The register breaks the read→merge→write timing path.
- RMW_WRITE:
  - stall=0, dm_write_enable=1, dm_write_data=merge_reg.
  - Upstream inputs are held stable by the stall, so dm_address is unchanged.
  - Next edge: go to IDLE, wb_valid=1, wb_reg_write=0.
- Simultaneous read and write: treated as a store; the load is ignored.
- Reset asserted during RMW_WRITE:
  - The write is aborted: dm_write_enable drops immediately because it is decoded from state.
  - State returns to IDLE and memory is unmodified.
- Back-to-back sub-word stores: each costs 2 cycles. The second is accepted in the IDLE cycle after RMW_WRITE.
- stall is asserted only in the first cycle of a sub-word store and is never asserted in RMW_WRITE.

Optional Feature:
- LSU_MISALIGN_CHECK_EN defined:
  - A half access with address[0]=1, or a word access with address[1:0]!=0, is suppressed: no write, no RMW, no stall.
  - The next edge sets misaligned=1 for one cycle, wb_valid=1, wb_reg_write=0.
- LSU_MISALIGN_CHECK_EN undefined:
  - misaligned is tied to 0.
  - Halves use address[1] and words ignore address[1:0]; the access proceeds as if aligned.

Decomposition:
- Shared package lsu_pkg holds:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - the state encoding IDLE=1'b0, RMW_WRITE=1'b1;
  - the data width constant 32.
- One combinational sub-module, lsu_lane_align, contains both:
  - load extract/extend: inputs word, size, offset, unsigned;
  - store merge: inputs old word, store data, size, offset.

Test Plan (bench uses a real word-addressed data memory, pre-loaded with word[1]=32'h8899_AABB):
- lb addr 0x4+3 (0x7), signed → wb_data=32'hFFFF_FF88 one cycle later; stall never asserted.
- lhu addr 0x6 → wb_data=32'h0000_8899; lh addr 0x4 → 32'hFFFF_AABB.
- sb addr 0x5, data 32'h0000_0011:
  - cycle 1: stall=1, no write;
  - cycle 2: dm_write_enable=1, dm_write_data=32'h8899_11BB;
  - a following lw addr 0x4 returns 32'h8899_11BB.
- sw addr 0x8, data 32'hDEAD_BEEF, followed immediately by sh addr 0xA, data 32'h1234 → word[2]=32'h1234_BEEF; total 3 cycles, stall asserted exactly once.
- Reset pulsed during RMW_WRITE of sb addr 0x4 → no write; word[1] unchanged; all outputs at reset values.
- With LSU_MISALIGN_CHECK_EN, lw addr 0x6 → misaligned=1 for one cycle, wb_reg_write=0, memory untouched. Without it → wb_data=word[1].
